mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit producing the HI and LO registers that feed
//   the CPU register-write mux (mfhi/mflo) and raise the divide-by-zero exception.

---
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit producing HI/LO, one bit per cycle.
// Optional macro MULT_DIV_UNSIGNED_EN adds an op_unsigned input for multu/divu.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             op_div;
  logic             neg_lo;     // sign of product or quotient
  logic             neg_hi;     // sign of remainder (dividend sign)
  logic [WIDTH-1:0] acc_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier being consumed / quotient being built
  logic [WIDTH-1:0] dvsr;       // magnitude of b

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef MULT_DIV_UNSIGNED_EN
  assign signed_op = ~op_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  // Negating INT_MIN yields 2^(W-1) when read as unsigned, which is exactly its magnitude.
  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    div_ge    = 1'b0;
    prod_fix  = '0;
    quo_fix   = '0;
    rem_fix   = '0;

    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvsr} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvsr};
    div_ge    = (div_shift >= {1'b0, dvsr});

    prod_fix  = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix   = neg_lo ? -acc_lo : acc_lo;
    rem_fix   = neg_hi ? -acc_hi : acc_hi;
  end

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      op_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      dvsr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div <= op;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            acc_hi <= '0;
            acc_lo <= a_mag;
            dvsr   <= b_mag;
            count  <= '0;
            busy   <= 1'b1;
            state  <= (op && (b == '0)) ? ZERO : CALC;
          end
        end

        CALC: begin
          if (op_div) begin
            // Restoring step: shift in the next dividend bit, subtract only if it fits.
            acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= FIX;
        end

        FIX: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        ZERO: begin
          done     <= 1'b1;
          div_zero <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed spec cases plus random ops against a 64-bit arithmetic model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULT_DIV_UNSIGNED_EN
  logic        op_unsigned = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
`ifdef MULT_DIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero with dividend-signed remainder.
  task automatic model_op(input logic o, input logic u, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr, sp;
    longint unsigned ux, uy, uq, ur, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    m_dz = 1'b0;
    if (o && y == 32'd0) begin
      m_dz = 1'b1;
    end else if (!o) begin
      if (u) begin up = ux * uy; m_hi = up[63:32]; m_lo = up[31:0]; end
      else   begin sp = sx * sy; m_hi = sp[63:32]; m_lo = sp[31:0]; end
    end else begin
      if (u) begin uq = ux / uy; ur = ux % uy; m_hi = ur[31:0]; m_lo = uq[31:0]; end
      else   begin sq = sx / sy; sr = sx % sy; m_hi = sr[31:0]; m_lo = sq[31:0]; end
    end
  endtask

  // Launches one op; lat = edges from the start-sampling edge until done is seen high.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    vectors++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, want all zero", busy, done, div_zero, hi, lo);
    end
    @(negedge clk); reset = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_directed();
    int lat;
    logic [31:0] ehi [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    logic [31:0] elo [4] = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'h80000000, 32'h0000000C};
    logic        eop [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ea  [4] = '{32'd7, 32'hFFFFFFF9, 32'h80000000, 32'd3};
    logic [31:0] eb  [4] = '{32'hFFFFFFFD, 32'd2, 32'hFFFFFFFF, 32'd4};
    for (int i = 0; i < 4; i++) begin
      run_op(eop[i], ea[i], eb[i], lat);
      model_op(eop[i], 1'b0, ea[i], eb[i]);
      vectors++;
      if (lat != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d, want 33", i, lat); end
      vectors++;
      if (hi !== ehi[i] || lo !== elo[i] || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_result: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=0", i, hi, lo, div_zero, ehi[i], elo[i]);
      end
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_after_done: got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    // hi=0, lo=12 preloaded by the last directed op (3*4)
    run_op(1'b1, 32'd5, 32'd0, lat);
    model_op(1'b1, 1'b0, 32'd5, 32'd0);
    vectors++;
    if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d, want 1", lat); end
    vectors++;
    if (div_zero !== 1'b1 || hi !== 32'd0 || lo !== 32'd12) begin
      errors++;
      $display("FAIL dz_result: got dz=%b hi=%h lo=%h, want dz=1 hi=0 lo=c", div_zero, hi, lo);
    end
    @(posedge clk); #1;
    vectors++;
    if (div_zero !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_pulse: got dz=%b done=%b busy=%b, want 0 0 0", div_zero, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    op = 1'b1; a = 32'd100; b = 32'd7;   // start stays high throughout the first op
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat != 33 || hi !== 32'd0 || lo !== 32'd15) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h, want 33 0 f", lat, hi, lo);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b, want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    model_op(1'b1, 1'b0, 32'd100, 32'd7);
    vectors++;
    if (lat != 33 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h, want 33 %h %h", lat, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL midreset: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    @(negedge clk); reset = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op(1'b0, 32'd6, 32'd7, lat);
    vectors++;
    if (lat != 33 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL midreset_restart: got lat=%0d hi=%h lo=%h, want 33 0 2a", lat, hi, lo);
    end
  endtask

  task automatic test_random();
    int lat, want_lat, sel;
    logic o, u;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom; y = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'd0;
      if (sel == 1) x = 32'h80000000;
      if (sel == 2) y = 32'hFFFFFFFF;
      if (sel == 3) y = $urandom_range(1, 300);
      u = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
      u = 1'($urandom_range(0, 1));
      op_unsigned = u;
`endif
      run_op(o, x, y, lat);
      model_op(o, u, x, y);
      want_lat = m_dz ? 1 : 33;
      vectors++;
      if (lat != want_lat || hi !== m_hi || lo !== m_lo || div_zero !== m_dz) begin
        errors++;
        $display("FAIL rand%0d op=%b u=%b a=%h b=%h: got lat=%0d hi=%h lo=%h dz=%b, want %0d %h %h %b",
                 i, o, u, x, y, lat, hi, lo, div_zero, want_lat, m_hi, m_lo, m_dz);
      end
    end
`ifdef MULT_DIV_UNSIGNED_EN
    op_unsigned = 1'b0;
`endif
  endtask

`ifdef MULT_DIV_UNSIGNED_EN
  task automatic test_unsigned();
    int lat;
    op_unsigned = 1'b1;
    run_op(1'b0, 32'hFFFFFFFF, 32'd2, lat);
    vectors++;
    if (lat != 33 || hi !== 32'd1 || lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu: got lat=%0d hi=%h lo=%h, want 33 1 fffffffe", lat, hi, lo);
    end
    run_op(1'b1, 32'hFFFFFFFF, 32'd2, lat);
    vectors++;
    if (lat != 33 || hi !== 32'd1 || lo !== 32'h7FFFFFFF) begin
      errors++;
      $display("FAIL divu: got lat=%0d hi=%h lo=%h, want 33 1 7fffffff", lat, hi, lo);
    end
    op_unsigned = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
`ifdef MULT_DIV_UNSIGNED_EN
    test_unsigned();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
